// File: rtl/digit_scan_mux_pkg.sv
// Shared constants and load-FSM encoding for the multiplexed digit display front end.
package digit_scan_mux_pkg;

    localparam int unsigned DIGIT_W = 4;

    // Anodes are active-low: a low pin lights the digit
    localparam logic ANODE_ON  = 1'b0;
    localparam logic ANODE_OFF = 1'b1;

    localparam logic [DIGIT_W-1:0] BLANK_NIBBLE = 4'h0;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } load_state_e;

endpackage : digit_scan_mux_pkg

// File: rtl/digit_scan_mux_if.sv
// Load/display bus between the display host and digit_scan_mux.
interface digit_scan_mux_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    localparam int unsigned DATA_W = digit_scan_mux_pkg::DIGIT_W * NUM_DIGITS;

    logic                                  Load;
    logic [DATA_W-1:0]                     Load_Data;
    logic                                  Load_Ack;
    logic                                  Blank_In;
    logic [digit_scan_mux_pkg::DIGIT_W-1:0] Digit_Out;
    logic [NUM_DIGITS-1:0]                 Anode_Out;

    modport master (
        output Load, Load_Data, Blank_In,
        input  Load_Ack, Digit_Out, Anode_Out
    );

    modport slave (
        input  Load, Load_Data, Blank_In,
        output Load_Ack, Digit_Out, Anode_Out
    );

endinterface : digit_scan_mux_if

// File: rtl/digit_scan_mux_scan_prescaler.sv
// Free-running 0..REFRESH_DIV-1 counter; tc_c marks the last cycle of each digit slot.
module digit_scan_mux_scan_prescaler #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tc_c
);

    localparam int unsigned        CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_c = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tc_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : digit_scan_mux_scan_prescaler

// File: rtl/digit_scan_mux.sv
// Scans a double-buffered packed digit word onto a shared decoder input with active-low anodes.
// Optional LEADING_ZERO_BLANK_EN suppresses the anodes of leading zero digits.
module digit_scan_mux
    import digit_scan_mux_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic             Clk,
    input  logic             Rst,
    digit_scan_mux_if.slave  bus
);

    localparam int unsigned         DATA_W   = DIGIT_W * NUM_DIGITS;
    localparam int unsigned         IDX_W    = $clog2(NUM_DIGITS);
    localparam int unsigned         SH_W     = $clog2(DATA_W);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic                   tc_c;
    logic                   frame_end_c;
    logic                   commit_c;
    logic [SH_W-1:0]        sh_c;

    logic [IDX_W-1:0]       idx_q,       idx_d;
    logic [DATA_W-1:0]      shadow_q,    shadow_d;
    logic [DATA_W-1:0]      display_q,   display_d;
    load_state_e            state_q,     state_d;
    logic                   ack_q,       ack_d;
    logic [DIGIT_W-1:0]     digit_out_q, digit_out_d;
    logic [NUM_DIGITS-1:0]  anode_out_q, anode_out_d;

    digit_scan_mux_scan_prescaler #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk   (Clk),
        .rst_n (Rst),
        .tc_c  (tc_c)
    );

    assign frame_end_c = tc_c && (idx_q == IDX_LAST);
    assign sh_c        = SH_W'(idx_q) * SH_W'(DIGIT_W);

`ifdef LEADING_ZERO_BLANK_EN
    // Current digit and everything to its left are zero: digit is a leading zero
    logic lead_zero_c;
    assign lead_zero_c = (idx_q != '0) && ((display_q >> sh_c) == '0);
`endif

    // Next-state logic for scan index, load FSM and registered outputs
    always_comb begin
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        display_d   = display_q;
        state_d     = state_q;
        commit_c    = 1'b0;

        if (tc_c) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        // Last write wins; a load coinciding with a commit lands after the commit reads shadow_q
        if (bus.Load) begin
            shadow_d = bus.Load_Data;
        end

        if (state_q == ST_IDLE) begin
            if (bus.Load) begin
                state_d = ST_PENDING;
            end
        end else begin
            if (frame_end_c) begin
                commit_c  = 1'b1;
                display_d = shadow_q;
                state_d   = bus.Load ? ST_PENDING : ST_IDLE;
            end
        end

        ack_d       = commit_c;
        digit_out_d = DIGIT_W'(display_q >> sh_c);

        anode_out_d        = {NUM_DIGITS{ANODE_OFF}};
        anode_out_d[idx_q] = ANODE_ON;
`ifdef LEADING_ZERO_BLANK_EN
        if (lead_zero_c) begin
            anode_out_d = {NUM_DIGITS{ANODE_OFF}};
        end
`endif
        if (bus.Blank_In) begin
            anode_out_d = {NUM_DIGITS{ANODE_OFF}};
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            idx_q       <= '0;
            shadow_q    <= '0;
            display_q   <= '0;
            state_q     <= ST_IDLE;
            ack_q       <= 1'b0;
            digit_out_q <= BLANK_NIBBLE;
            anode_out_q <= {NUM_DIGITS{ANODE_OFF}};
        end else begin
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            display_q   <= display_d;
            state_q     <= state_d;
            ack_q       <= ack_d;
            digit_out_q <= digit_out_d;
            anode_out_q <= anode_out_d;
        end
    end

    assign bus.Load_Ack  = ack_q;
    assign bus.Digit_Out = digit_out_q;
    assign bus.Anode_Out = anode_out_q;

endmodule : digit_scan_mux

// File: tb/tb_digit_scan_mux.sv
// Bench for digit_scan_mux (4 digits, 4 clocks per digit): directed loads, scoreboard on Load_Ack.
module tb_digit_scan_mux;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ_EN = 1'b1;
`else
    localparam bit LZ_EN = 1'b0;
`endif

    logic Clk;
    logic Rst;
    int   tests;
    int   fails;
    int   edges;
    logic [15:0] exp_q[$];

    digit_scan_mux_if #(.NUM_DIGITS(4)) bus ();

    digit_scan_mux #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Posedges since reset release; edge n is the n-th rising edge with Rst high
    always @(posedge Clk or negedge Rst) begin
        if (!Rst) edges <= 0;
        else      edges <= edges + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_anode(input int k, input logic [15:0] disp, input bit blank);
        logic [3:0] a;
        a = 4'b1111;
        if (!blank) a[k] = 1'b0;
        if (LZ_EN && k > 0 && ((disp >> (4 * k)) == 16'h0)) a = 4'b1111;
        return a;
    endfunction

    // Land on the falling edge that follows rising edge n
    task automatic wait_after(input int n);
        int guard;
        guard = 0;
        while (edges < n && guard < 2000) begin
            @(negedge Clk);
            guard++;
        end
        if (edges != n) begin
            tests++;
            fails++;
            $display("FAIL wait_after: edge count %0d expected %0d", edges, n);
        end
    endtask

    // Monitor: each Load_Ack pops the expected committed word and checks the following frame
    initial begin : monitor
        logic [15:0] word;
        forever begin
            @(negedge Clk);
            if (Rst === 1'b1 && bus.Load_Ack === 1'b1) begin
                check("ack_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    word = exp_q.pop_front();
                    @(negedge Clk);
                    check("ack_one_cycle", 32'(bus.Load_Ack), 32'd0);
                    for (int k = 0; k < 4; k++) begin
                        if (k > 0) repeat (4) @(negedge Clk);
                        check("commit_anode", 32'(bus.Anode_Out), 32'(exp_anode(k, word, 1'b0)));
                        check("commit_digit", 32'(bus.Digit_Out), 32'(word[4*k +: 4]));
                    end
                end
            end
        end
    end

    initial begin : stimulus
        tests = 0;
        fails = 0;
        Rst = 1'b0;
        bus.Load = 1'b0;
        bus.Load_Data = 16'h0;
        bus.Blank_In = 1'b0;
        repeat (2) @(negedge Clk);

        check("rst_anode", 32'(bus.Anode_Out), 32'hF);
        check("rst_digit", 32'(bus.Digit_Out), 32'h0);
        check("rst_ack",   32'(bus.Load_Ack),  32'h0);
        Rst = 1'b1;

        // Free scan with an all-zero display
        for (int n = 1; n <= 17; n++) begin
            wait_after(n);
            check("scan_anode", 32'(bus.Anode_Out), 32'(exp_anode(((n - 1) / 4) % 4, 16'h0, 1'b0)));
            check("scan_digit", 32'(bus.Digit_Out), 32'h0);
        end

        // Mid-frame load waits for the frame boundary at edge 32
        wait_after(20);
        bus.Load = 1'b1; bus.Load_Data = 16'h1234; exp_q.push_back(16'h1234);
        wait_after(21);
        bus.Load = 1'b0;
        for (int n = 22; n <= 31; n++) begin
            wait_after(n);
            check("hold_digit", 32'(bus.Digit_Out), 32'h0);
            check("hold_ack",   32'(bus.Load_Ack),  32'h0);
        end
        wait_after(32);
        check("ack_1234", 32'(bus.Load_Ack), 32'h1);

        // Two loads in one frame: last write wins, single ack at edge 64
        wait_after(49);
        bus.Load = 1'b1; bus.Load_Data = 16'hAAAA;
        wait_after(50);
        bus.Load = 1'b0;
        wait_after(54);
        bus.Load = 1'b1; bus.Load_Data = 16'h5678; exp_q.push_back(16'h5678);
        wait_after(55);
        bus.Load = 1'b0;
        wait_after(64);
        check("ack_5678", 32'(bus.Load_Ack), 32'h1);

        // Load on the boundary cycle while pending: 1111 commits at 80, 9999 at 96
        wait_after(69);
        bus.Load = 1'b1; bus.Load_Data = 16'h1111; exp_q.push_back(16'h1111);
        wait_after(70);
        bus.Load = 1'b0;
        wait_after(79);
        bus.Load = 1'b1; bus.Load_Data = 16'h9999; exp_q.push_back(16'h9999);
        wait_after(80);
        bus.Load = 1'b0;
        check("ack_1111", 32'(bus.Load_Ack), 32'h1);
        wait_after(95);
        check("no_early_ack", 32'(bus.Load_Ack), 32'h0);
        wait_after(96);
        check("ack_9999", 32'(bus.Load_Ack), 32'h1);

        // Blank for six edges; scan phase must be preserved
        wait_after(113);
        bus.Blank_In = 1'b1;
        for (int n = 114; n <= 119; n++) begin
            wait_after(n);
            check("blank_anode", 32'(bus.Anode_Out), 32'hF);
            check("blank_digit", 32'(bus.Digit_Out), 32'h9);
        end
        bus.Blank_In = 1'b0;
        for (int n = 120; n <= 124; n++) begin
            wait_after(n);
            check("unblank_anode", 32'(bus.Anode_Out), 32'(exp_anode(((n - 1) / 4) % 4, 16'h9999, 1'b0)));
        end

        // Reset while pending discards the shadow value
        wait_after(129);
        bus.Load = 1'b1; bus.Load_Data = 16'h7777;
        wait_after(130);
        bus.Load = 1'b0;
        wait_after(135);
        Rst = 1'b0;
        #1;
        check("midrst_anode", 32'(bus.Anode_Out), 32'hF);
        check("midrst_digit", 32'(bus.Digit_Out), 32'h0);
        check("midrst_ack",   32'(bus.Load_Ack),  32'h0);
        @(negedge Clk);
        Rst = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            wait_after(n);
            check("postrst_digit", 32'(bus.Digit_Out), 32'h0);
            check("postrst_ack",   32'(bus.Load_Ack),  32'h0);
            check("postrst_anode", 32'(bus.Anode_Out), 32'(exp_anode(((n - 1) / 4) % 4, 16'h0, 1'b0)));
        end

        // Leading-zero case: 0040 lights digits 0,1 only when suppression is built in
        wait_after(21);
        bus.Load = 1'b1; bus.Load_Data = 16'h0040; exp_q.push_back(16'h0040);
        wait_after(22);
        bus.Load = 1'b0;
        wait_after(32);
        check("ack_0040", 32'(bus.Load_Ack), 32'h1);
        wait_after(50);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_digit_scan_mux
